line_buffer_3x3: RTL
====================

# line_buffer_3x3

Streaming 3×3 neighbourhood generator placed directly after `rgb_to_grayscale` and before the Sobel gradient stage. It accepts one 8-bit grayscale pixel per `done_i` strobe in raster order. It stores the two previous image rows in internal line buffers and presents a registered 3×3 window with a `done_o` strobe for every pixel position whose full neighbourhood lies inside the image (no border padding).

## Interface
- `IMG_WIDTH`, default 256: pixels per row; legal range ≥ 3.
- `IMG_HEIGHT`, default 256: rows per frame; legal range ≥ 3.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `grayscale_i` input 8: incoming pixel, driven by the `grayscale_o` output of the upstream stage.
- `done_i` input 1: pixel valid; the pixel is accepted on every rising edge where this is high.
- `p00_o` … `p22_o` output 8 each (9 ports): window pixels, `pRC` with R = row (0 = oldest/top), C = column (0 = leftmost). `p22_o` is the newest pixel.
- `done_o` output 1: window valid, one-cycle pulse per complete window.
- `frame_done_o` output 1: present only with `LINE_BUFFER_FRAME_DONE_EN` (see Configuration).

## Operation
- Counters:
  - `col` has width $clog2(IMG_WIDTH) and runs 0..IMG_WIDTH-1.
  - `row` has width $clog2(IMG_HEIGHT) and runs 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels.
  - At `col = IMG_WIDTH-1`, `col` wraps to 0 and `row` increments.
  - At (`row = IMG_HEIGHT-1`, `col = IMG_WIDTH-1`), both wrap to 0 and the next frame begins without a gap.
- Line buffers: `lb0` holds row r-1 and `lb1` holds row r-2. Each is IMG_WIDTH × 8, with combinational read at index `col`.
- On an accepted pixel p at position (r, c):
  - New column is {`lb1[c]`, `lb0[c]`, p}, ordered top to bottom.
  - Write `lb1[c]` ← `lb0[c]` and `lb0[c]` ← p.
  - Window shifts left: column 0 ← column 1, column 1 ← column 2, column 2 ← new column.
- `done_o` is set on the accepting edge when r ≥ 2 and c ≥ 2, and cleared on every other edge.
  - Windows at c = 0 or 1 contain stale data from the previous row; they are suppressed by this rule.
  - Per frame there are exactly (IMG_WIDTH-2)·(IMG_HEIGHT-2) `done_o` pulses.
- When `done_i` is low:
  - Nothing shifts or is written.
  - Counters hold.
  - `p*_o` hold their last values.
  - `done_o` = 0.
- Arithmetic: no pixel arithmetic is performed; values pass through unchanged at 8 bits.
- Line buffer contents need no initialisation, because the r ≥ 2 gating masks them.

## Timing
- Reset values, applied immediately on `rst` assertion independent of `clk`:
  - `col` = 0, `row` = 0.
  - All `p*_o` = 0.
  - `done_o` = 0.
  - `frame_done_o` = 0.
- Line buffer RAM is not reset.
- Latency: one cycle. The window containing pixel (r, c) as `p22_o`, together with its `done_o`, is visible in the cycle after `done_i` samples that pixel.
- Throughput: one pixel per cycle; `done_i` may be high continuously or have arbitrary gaps.
- There is no backpressure; downstream must accept every `done_o` pulse.
- Reset mid-frame:
  - Counters return to 0 and the next accepted pixel is treated as (0, 0) of a new frame.
  - No `done_o` occurs until that frame's row 2, col 2.
- `rst` and `done_i` high on the same edge: reset wins and the pixel is dropped.

## Configuration
- Macro `LINE_BUFFER_FRAME_DONE_EN`.
- Defined:
  - Output port `frame_done_o` exists.
  - It is a registered one-cycle pulse, high in the same cycle as the `done_o` of the window at (IMG_HEIGHT-1, IMG_WIDTH-1), i.e. the last window of the frame.
  - It is 0 at all other times.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use IMG_WIDTH = 4, IMG_HEIGHT = 4, with pixel value = 4r + c + 1 (values 1..16).
- Continuous stream of one frame:
  - First `done_o` comes one cycle after pixel 11 is accepted, with window 1,2,3 / 5,6,7 / 9,10,11.
  - Exactly 4 pulses in the frame.
  - Last window is 6,7,8 / 10,11,12 / 14,15,16.
- Same frame with random 0–3 cycle gaps in `done_i`:
  - Identical window sequence.
  - Outputs hold and `done_o` = 0 during gaps.
- Two back-to-back frames (second frame uses value + 100):
  - No `done_o` during rows 0–1 of frame 2.
  - First window of frame 2 is 101,102,103 / 105,106,107 / 109,110,111.
- Assert `rst` asynchronously after pixel 10 of a frame, then restart a full frame:
  - All outputs read 0 before the next clock edge.
  - Restarted frame produces exactly the 4 windows of scenario 1.
- With `LINE_BUFFER_FRAME_DONE_EN` defined:
  - `frame_done_o` pulses exactly once per frame, coincident with the window ending in pixel 16.
- With the macro undefined:
  - Build has no `frame_done_o` port.
  - Scenario 1 results are unchanged.

Source files
------------

// File: rtl/line_buffer_3x3.sv
// Streaming 3x3 window generator: two row line buffers feed a shifting window register.
// Optional `LINE_BUFFER_FRAME_DONE_EN adds a frame_done_o pulse on the last window of each frame.
module line_buffer_3x3 #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] grayscale_i,
  input  logic       done_i,
  output logic [7:0] p00_o,
  output logic [7:0] p01_o,
  output logic [7:0] p02_o,
  output logic [7:0] p10_o,
  output logic [7:0] p11_o,
  output logic [7:0] p12_o,
  output logic [7:0] p20_o,
  output logic [7:0] p21_o,
  output logic [7:0] p22_o,
  output logic       done_o
`ifdef LINE_BUFFER_FRAME_DONE_EN
  ,
  output logic       frame_done_o
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    win_q [3][3];
  logic [7:0]    win_d [3][3];
  logic          done_q, done_d;

  // lb0 holds the previous row, lb1 the row before that.
  logic [7:0] lb0_q [IMG_WIDTH];
  logic [7:0] lb1_q [IMG_WIDTH];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    col_d  = col_q;
    row_d  = row_q;
    win_d  = win_q;
    done_d = 1'b0;
    if (done_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb1_q[col_q];
      win_d[1][2] = lb0_q[col_q];
      win_d[2][2] = grayscale_i;
      // Columns 0/1 still hold the tail of the previous row, so those windows are suppressed.
      done_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      win_q  <= '{default: '0};
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      win_q  <= win_d;
      done_q <= done_d;
    end
  end

  // NOTE: the line buffers are RAM and deliberately have no reset; the row >= 2 gating masks stale data.
  always_ff @(posedge clk) begin
    if (done_i && !rst) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= grayscale_i;
    end
  end

`ifdef LINE_BUFFER_FRAME_DONE_EN
  logic frame_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= done_i && (row_q == ROW_LAST) && (col_q == COL_LAST);
    end
  end

  assign frame_done_o = frame_done_q;
`endif

  assign p00_o  = win_q[0][0];
  assign p01_o  = win_q[0][1];
  assign p02_o  = win_q[0][2];
  assign p10_o  = win_q[1][0];
  assign p11_o  = win_q[1][1];
  assign p12_o  = win_q[1][2];
  assign p20_o  = win_q[2][0];
  assign p21_o  = win_q[2][1];
  assign p22_o  = win_q[2][2];
  assign done_o = done_q;

endmodule
